// File: rtl/fifo_pkg.sv
// Shared definitions for both halves of the asynchronous FIFO: default geometry
// and the Gray/binary pointer conversions used by the read and write controllers.
package fifo_pkg;

  localparam int unsigned N_DEF     = 3;
  localparam int unsigned DEPTH_DEF = 2 ** N_DEF;
  localparam int unsigned CONV_W    = 32;

  // Both conversions work for any pointer width up to CONV_W when the caller
  // zero-extends the input and truncates the result.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = '0;
    for (int i = 0; i < CONV_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser for Gray pointers crossing clock
// domains; shared by the read and write controllers.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // their inputs at the same edge and the pair behaves as a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: synchronises the write Gray
// pointer, advances the read pointers on pops and registers empty/count flags.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AE = 1
) (
  input  logic       r_clk,
  input  logic       r_rst_n,
  input  logic       r_en,
  input  logic [N:0] gwptr,
  output logic [N:0] brptr,
  output logic [N:0] grptr,
  output logic       empty,
  output logic       almost_empty,
  output logic [N:0] rd_count,
  output logic       r_valid
);

  localparam int PW = N + 1;

  logic [N:0] wq2;
  logic       pop;
  logic [N:0] brptr_nx;
  logic [N:0] grptr_nx;
  logic [N:0] wbin;
  logic [N:0] rd_count_nx;
  logic       empty_nx;
  logic       almost_empty_nx;

  sync_2ff #(
    .W (PW)
  ) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .d     (gwptr),
    .q     (wq2)
  );

  // A request against an empty FIFO is dropped; nothing below sees it.
  always_comb begin
    pop             = r_en & ~empty;
    brptr_nx        = brptr + PW'(pop);
    grptr_nx        = PW'(bin2gray(CONV_W'(brptr_nx)));
    wbin            = PW'(gray2bin(CONV_W'(wq2)));
    rd_count_nx     = wbin - brptr_nx;
    empty_nx        = (grptr_nx == wq2);
    almost_empty_nx = (CONV_W'(rd_count_nx) <= CONV_W'(AE));
  end

  // NOTE: every register here takes its reset value asynchronously so the
  // consumer sees empty the moment reset asserts, without waiting for a clock.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      brptr        <= '0;
      grptr        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      r_valid      <= 1'b0;
    end else begin
      brptr        <= brptr_nx;
      grptr        <= grptr_nx;
      empty        <= empty_nx;
      almost_empty <= almost_empty_nx;
      rd_count     <= rd_count_nx;
      r_valid      <= pop;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed fill/drain/full/simultaneous
// scenarios plus random traffic against an occupancy-level reference model.
module tb_fifo_rd_ctrl;

  localparam int N   = 3;
  localparam int AE  = 1;
  localparam int PW  = N + 1;
  localparam int MOD = 2 ** PW;

  logic          r_clk = 1'b0;
  logic          r_rst_n = 1'b0;
  logic          r_en = 1'b0;
  logic [PW-1:0] gwptr = '0;
  logic [PW-1:0] brptr;
  logic [PW-1:0] grptr;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] rd_count;
  logic          r_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: total pops, the write pointers sampled at the last two
  // edges (a write counts two edges after it is sampled), and the flags.
  int m_rd;
  int m_smp1;
  int m_smp2;
  int m_count;
  bit m_empty;
  bit m_valid;

  int n_wraps = 0;
  int prev_brptr = 0;

  fifo_rd_ctrl #(
    .N  (N),
    .AE (AE)
  ) dut (
    .r_clk        (r_clk),
    .r_rst_n      (r_rst_n),
    .r_en         (r_en),
    .gwptr        (gwptr),
    .brptr        (brptr),
    .grptr        (grptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .r_valid      (r_valid)
  );

  always #5 r_clk = ~r_clk;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int from_gray(input int g);
    int b;
    b = g;
    for (int s = 1; s < PW; s++) b = b ^ (g >> s);
    return b % MOD;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd    = 0;
    m_smp1  = 0;
    m_smp2  = 0;
    m_count = 0;
    m_empty = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".brptr"}, 32'(brptr), 32'(m_rd % MOD));
    check({ph, ".grptr"}, 32'(grptr), 32'(to_gray(m_rd % MOD)));
    check({ph, ".empty"}, 32'(empty), 32'(m_empty));
    check({ph, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= AE));
    check({ph, ".rd_count"}, 32'(rd_count), 32'(m_count));
    check({ph, ".r_valid"}, 32'(r_valid), 32'(m_valid));
  endtask

  task automatic check_reset_vals(input string ph);
    check({ph, ".brptr"}, 32'(brptr), 0);
    check({ph, ".grptr"}, 32'(grptr), 0);
    check({ph, ".empty"}, 32'(empty), 1);
    check({ph, ".almost_empty"}, 32'(almost_empty), 1);
    check({ph, ".rd_count"}, 32'(rd_count), 0);
    check({ph, ".r_valid"}, 32'(r_valid), 0);
  endtask

  // One clock: present inputs, let the edge happen, advance the model, compare.
  task automatic tick(input string ph, input logic en, input int wr_total);
    bit pop;
    r_en  = en;
    gwptr = PW'(to_gray(wr_total % MOD));
    @(posedge r_clk);
    pop     = en && !m_empty;
    m_rd    = m_rd + int'(pop);
    m_valid = pop;
    m_count = (from_gray(m_smp2) - (m_rd % MOD) + MOD) % MOD;
    m_empty = (m_count == 0);
    m_smp2  = m_smp1;
    m_smp1  = int'(gwptr);
    #1;
    if (prev_brptr == MOD - 1 && int'(brptr) == 0) n_wraps++;
    prev_brptr = int'(brptr);
    check_all(ph);
  endtask

  initial begin
    int w;
    model_reset();

    // Reset held while the write pointer moves.
    for (int i = 0; i < 4; i++) begin
      @(negedge r_clk);
      gwptr = PW'($urandom_range(0, MOD - 1));
      @(posedge r_clk);
      #1;
      check_reset_vals("hold_rst");
    end
    @(negedge r_clk);
    gwptr   = '0;
    r_rst_n = 1'b1;

    // Fill with three writes, then let them become visible.
    w = 0;
    tick("idle", 1'b0, w);
    for (int i = 1; i <= 3; i++) begin
      w = i;
      tick("fill", 1'b0, w);
    end
    for (int i = 0; i < 3; i++) tick("fill_settle", 1'b0, w);
    check("fill.count3", 32'(rd_count), 3);

    // Drain with r_en held; the fourth and fifth requests are ignored.
    for (int i = 0; i < 5; i++) tick("drain", 1'b1, w);
    check("drain.brptr_stays3", 32'(brptr), 3);
    check("drain.ignored_valid", 32'(r_valid), 0);

    // Pop in the same cycle the synchronised write pointer advances.
    w = 4;
    for (int i = 0; i < 3; i++) tick("simul_prep", 1'b0, w);
    w = 5;
    tick("simul_wq1", 1'b0, w);
    tick("simul_wq2", 1'b0, w);
    tick("simul_pop", 1'b1, w);
    check("simul.count", 32'(rd_count), 1);
    check("simul.empty", 32'(empty), 0);
    check("simul.valid", 32'(r_valid), 1);

    // Asynchronous reset between edges clears outputs before the next edge.
    tick("pre_rst", 1'b1, w);
    #3;
    r_rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    gwptr = '0;
    @(posedge r_clk);
    #3;
    r_rst_n = 1'b1;

    // Full as seen by the reader: Gray(8) with brptr at 0.
    w = 8;
    for (int i = 0; i < 4; i++) tick("full", 1'b0, w);
    check("full.count8", 32'(rd_count), 8);
    check("full.not_empty", 32'(empty), 0);
    for (int i = 0; i < 10; i++) tick("full_drain", 1'b1, w);
    check("full_drain.empty", 32'(empty), 1);
    check("full_drain.brptr", 32'(brptr), 8);

    // Random traffic; the writer never overfills the model's occupancy.
    for (int i = 0; i < 400; i++) begin
      if ((w - m_rd) < 2 ** N && $urandom_range(0, 1) == 1) w++;
      tick("rand", 1'($urandom_range(0, 2) != 0), w);
    end
    check("rand.wrap_seen", 32'(n_wraps > 1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
